// File: rtl/pipeline_hazard_ctrl.sv
// RAW hazard detection and branch flush control for a 5-stage pipeline.
// A small destination scoreboard tracks the EX/MEM/WB writers; branch flush wins over stall.
module pipeline_hazard_ctrl #(
  parameter int CNT_W    = 16,
  parameter int ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rm,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic             id_regwrite,
  input  logic [4:0]       id_rd,
  input  logic             mem_branch_taken,
  output logic             pc_write_en,
  output logic             ifid_write_en,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10
  } state_e;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
  } sb_entry_t;

  localparam logic [4:0] ZR = 5'(ZERO_REG);

  sb_entry_t        r_ex, r_mem, r_wb;
  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  logic w_rn_hit, w_rm_hit, w_hazard, w_flush, w_stall;

  function automatic logic f_match(sb_entry_t e, logic [4:0] src, logic uses);
    return e.v && (e.rd == src) && (src != ZR) && uses;
  endfunction

  // The WB entry is included because the register file does not forward writes.
  assign w_rn_hit = f_match(r_ex, id_rn, id_uses_rn) | f_match(r_mem, id_rn, id_uses_rn) |
                    f_match(r_wb, id_rn, id_uses_rn);
  assign w_rm_hit = f_match(r_ex, id_rm, id_uses_rm) | f_match(r_mem, id_rm, id_uses_rm) |
                    f_match(r_wb, id_rm, id_uses_rm);
  assign w_hazard = id_valid & (w_rn_hit | w_rm_hit);
  assign w_flush  = mem_branch_taken;
  assign w_stall  = w_hazard & ~w_flush;

  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    pc_write_en   = 1'b1;
    ifid_write_en = 1'b1;
    idex_bubble   = 1'b0;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    exmem_flush   = 1'b0;
    if (w_flush) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (w_stall) begin
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      idex_bubble   = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = ST_RUN;
    if (w_flush)      w_state_nxt = ST_FLUSH;
    else if (w_stall) w_state_nxt = ST_STALL;
  end

  // NOTE: sequential state uses non-blocking assignments so all stages shift together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex    <= '0;
      r_mem   <= '0;
      r_wb    <= '0;
      r_state <= ST_RUN;
    end else begin
      r_ex.v  <= id_valid & id_regwrite & ~w_stall & ~w_flush;
      r_ex.rd <= id_rd;
      r_mem   <= w_flush ? sb_entry_t'('0) : r_ex;
      r_wb    <= r_mem;
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign state        = r_state;
  assign stall_cycles = r_stall_cnt;
  assign flush_events = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: driver pushes hand-computed expectations,
// monitors pop and compare. A CNT_W=4 copy runs in parallel to exercise saturation.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rn = '0, id_rm = '0, id_rd = '0;
  logic       id_uses_rn = 1'b0, id_uses_rm = 1'b0, id_regwrite = 1'b0;
  logic       mem_branch_taken = 1'b0;

  logic        pc_we, ifid_we, bubble, ifid_fl, idex_fl, exmem_fl;
  logic [1:0]  st;
  logic [15:0] stall_cnt, flush_cnt;

  logic        pc_we4, ifid_we4, bubble4, ifid_fl4, idex_fl4, exmem_fl4;
  logic [1:0]  st4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  pipeline_hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .id_regwrite(id_regwrite),
    .id_rd(id_rd), .mem_branch_taken(mem_branch_taken),
    .pc_write_en(pc_we), .ifid_write_en(ifid_we), .idex_bubble(bubble),
    .ifid_flush(ifid_fl), .idex_flush(idex_fl), .exmem_flush(exmem_fl),
    .state(st), .stall_cycles(stall_cnt), .flush_events(flush_cnt)
  );

  pipeline_hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .id_regwrite(id_regwrite),
    .id_rd(id_rd), .mem_branch_taken(mem_branch_taken),
    .pc_write_en(pc_we4), .ifid_write_en(ifid_we4), .idex_bubble(bubble4),
    .ifid_flush(ifid_fl4), .idex_flush(idex_fl4), .exmem_flush(exmem_fl4),
    .state(st4), .stall_cycles(stall_cnt4), .flush_events(flush_cnt4)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    bit    pc;
    bit    bub;
    bit    fl;
    int    st;
    int    stall;
    int    fcnt;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  event async_ev;

  task automatic chk(input string tag, input string what, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %0d, expected %0d", tag, what, act, exp);
    end
  endtask

  task automatic compare(input exp_t e);
    int sat4;
    sat4 = (e.stall > 15) ? 15 : e.stall;
    chk(e.tag, "pc_write_en",   32'(pc_we),     32'(e.pc));
    chk(e.tag, "ifid_write_en", 32'(ifid_we),   32'(e.pc));
    chk(e.tag, "idex_bubble",   32'(bubble),    32'(e.bub));
    chk(e.tag, "ifid_flush",    32'(ifid_fl),   32'(e.fl));
    chk(e.tag, "idex_flush",    32'(idex_fl),   32'(e.fl));
    chk(e.tag, "exmem_flush",   32'(exmem_fl),  32'(e.fl));
    chk(e.tag, "state",         32'(st),        32'(e.st));
    chk(e.tag, "stall_cycles",  32'(stall_cnt), 32'(e.stall));
    chk(e.tag, "flush_events",  32'(flush_cnt), 32'(e.fcnt));
    chk(e.tag, "w4.stall_cycles", 32'(stall_cnt4), 32'(sat4));
    chk(e.tag, "w4.flush_events", 32'(flush_cnt4), 32'(e.fcnt));
    chk(e.tag, "w4.pc_write_en",  32'(pc_we4),     32'(e.pc));
  endtask

  // Clocked monitor: one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) compare(q.pop_front());
  end

  // Asynchronous monitor: for checks made between clock edges.
  always @(async_ev) begin
    if (q.size() > 0) compare(q.pop_front());
  end

  task automatic cyc(input string tag, input bit v, input logic [4:0] rn, input bit urn,
                     input logic [4:0] rm, input bit urm, input bit rw, input logic [4:0] rd,
                     input bit br, input bit pc, input bit bub, input int est,
                     input int stall, input int fcnt);
    @(posedge clk);
    #1;
    id_valid = v; id_rn = rn; id_uses_rn = urn; id_rm = rm; id_uses_rm = urm;
    id_regwrite = rw; id_rd = rd; mem_branch_taken = br;
    q.push_back('{tag, pc, bub, br, est, stall, fcnt});
  endtask

  task automatic nop(input string tag, input int est, input int stall, input int fcnt);
    cyc(tag, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 0, est, stall, fcnt);
  endtask

  task automatic wr(input string tag, input logic [4:0] rd, input int est, input int stall,
                    input int fcnt);
    cyc(tag, 1, 5'd0, 0, 5'd0, 0, 1, rd, 0, 1, 0, est, stall, fcnt);
  endtask

  task automatic rd_op(input string tag, input logic [4:0] rn, input bit urn,
                       input logic [4:0] rm, input bit urm, input bit pc, input bit bub,
                       input int est, input int stall, input int fcnt);
    cyc(tag, 1, rn, urn, rm, urm, 0, 5'd0, 0, pc, bub, est, stall, fcnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state with idle inputs.
    nop("rst0", 0, 0, 0);
    nop("rst1", 0, 0, 0);
    @(negedge clk); #1 reset = 1'b0;

    // RAW on rn: three stall cycles while the writer drains EX->MEM->WB.
    wr("A.add", 5'd1, 0, 0, 0);
    rd_op("A.sub_ex",  5'd1, 1, 5'd4, 1, 0, 1, 0, 0, 0);
    rd_op("A.sub_mem", 5'd1, 1, 5'd4, 1, 0, 1, 1, 1, 0);
    rd_op("A.sub_wb",  5'd1, 1, 5'd4, 1, 0, 1, 1, 2, 0);
    rd_op("A.sub_go",  5'd1, 1, 5'd4, 1, 1, 0, 1, 3, 0);
    nop("A.after", 0, 3, 0);

    // XZR never a hazard; unused operands never a hazard; rm path via MEM and WB.
    wr("B.w31", 5'd31, 0, 3, 0);
    rd_op("B.r31_ex",  5'd31, 1, 5'd31, 1, 1, 0, 0, 3, 0);
    rd_op("B.r31_mem", 5'd31, 1, 5'd31, 1, 1, 0, 0, 3, 0);
    rd_op("B.r31_wb",  5'd31, 1, 5'd31, 1, 1, 0, 0, 3, 0);
    wr("B.w8", 5'd8, 0, 3, 0);
    rd_op("B.unused", 5'd8, 0, 5'd8, 0, 1, 0, 0, 3, 0);
    rd_op("B.rm_mem", 5'd9, 1, 5'd8, 1, 0, 1, 0, 3, 0);
    rd_op("B.rm_wb",  5'd9, 1, 5'd8, 1, 0, 1, 1, 4, 0);
    rd_op("B.rm_go",  5'd9, 1, 5'd8, 1, 1, 0, 1, 5, 0);

    // Independent instructions.
    wr("C.w2", 5'd2, 0, 5, 0);
    wr("C.w3", 5'd3, 0, 5, 0);
    wr("C.w4", 5'd4, 0, 5, 0);
    rd_op("C.indep", 5'd5, 1, 5'd6, 1, 1, 0, 0, 5, 0);
    nop("C.run0", 0, 5, 0);
    nop("C.run1", 0, 5, 0);

    // Flush wins over a simultaneous hazard; EX/MEM are invalid afterwards.
    wr("D.w7", 5'd7, 0, 5, 0);
    cyc("D.flush", 1, 5'd7, 1, 5'd0, 0, 1, 5'd10, 1, 1, 0, 0, 5, 0);
    rd_op("D.post", 5'd7, 1, 5'd10, 1, 1, 0, 2, 5, 1);
    nop("D.run", 0, 5, 1);

    // Reset in the second stall cycle releases the stall without a clock edge.
    wr("E.w12", 5'd12, 0, 5, 1);
    rd_op("E.s1", 5'd12, 1, 5'd0, 0, 0, 1, 0, 5, 1);
    rd_op("E.s2", 5'd12, 1, 5'd0, 0, 0, 1, 1, 6, 1);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    q.push_back('{"E.async", 1'b1, 1'b0, 1'b0, 0, 0, 0});
    ->async_ev;
    nop("E.held", 0, 0, 0);
    @(negedge clk); #1 reset = 1'b0;

    // Seven back-to-back dependencies: 21 stall cycles, 4-bit copy saturates at 15.
    for (int k = 0; k < 7; k++) begin
      wr($sformatf("F%0d.w", k), 5'(k + 1), 0, 3 * k, 0);
      rd_op($sformatf("F%0d.r1", k), 5'(k + 1), 1, 5'd0, 0, 0, 1, 0, 3 * k, 0);
      rd_op($sformatf("F%0d.r2", k), 5'(k + 1), 1, 5'd0, 0, 0, 1, 1, 3 * k + 1, 0);
      rd_op($sformatf("F%0d.r3", k), 5'(k + 1), 1, 5'd0, 0, 0, 1, 1, 3 * k + 2, 0);
      rd_op($sformatf("F%0d.go", k), 5'(k + 1), 1, 5'd0, 0, 1, 0, 1, 3 * k + 3, 0);
    end
    nop("F.end", 0, 21, 0);

    repeat (3) @(posedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter CNT_W, default 16: width of the performance counters.
REQ-002 Parameter ZERO_REG, default 31: register index that is never a hazard source (XZR).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-005 id_valid  in  1  IF/ID holds a real instruction.
REQ-006 id_rn  in  5  first source register of the ID instruction (IFID[9:5]).
REQ-007 id_rm  in  5  second source register after the ReadRegister_2 mux.
REQ-008 id_uses_rn, id_uses_rm  in  1 each  source operand is actually read.
REQ-009 id_regwrite  in  1  RegWrite decoded for the ID instruction.
REQ-010 id_rd  in  5  destination register of the ID instruction (IFID[4:0]).
REQ-011 mem_branch_taken  in  1  Branch AND zero of the instruction in MEM.
REQ-012 pc_write_en  out  1  PC register load enable.
REQ-013 ifid_write_en  out  1  IF/ID load enable.
REQ-014 idex_bubble  out  1  force ID/EX control fields to zero (NOP).
REQ-015 ifid_flush, idex_flush, exmem_flush  out  1 each  clear the named pipeline register's control fields.
REQ-016 state  out  2  00 RUN, 01 STALL, 10 FLUSH.
REQ-017 stall_cycles, flush_events  out  CNT_W each  saturating performance counters.

Function
REQ-018 The block SHALL hold a 3-entry scoreboard {v, rd} for the EX, MEM, WB stages; all entries shift one stage per clock.
REQ-019 Next EX entry SHALL be {id_valid & id_regwrite & ~stall & ~flush, id_rd}; next MEM entry SHALL be cleared on flush, else take EX; next WB SHALL take MEM unconditionally.
REQ-020 An entry SHALL match when v=1, rd=src, src!=ZERO_REG, and the corresponding id_uses_* =1; the WB entry counts (register file has no write-through).
REQ-021 hazard SHALL be id_valid AND any match on rn or rm, combinational from scoreboard and ID inputs.
REQ-022 flush = mem_branch_taken; flush SHALL take priority over hazard in the same cycle.
REQ-023 On flush: ifid_flush=idex_flush=exmem_flush=1, pc_write_en=1, ifid_write_en=1, idex_bubble=0, same cycle (zero latency).
REQ-024 On stall (hazard & ~flush): pc_write_en=0, ifid_write_en=0, idex_bubble=1; all flushes 0.
REQ-025 Otherwise: pc_write_en=ifid_write_en=1, idex_bubble=0, all flushes 0.
REQ-026 state register SHALL record the action taken in the previous cycle: FLUSH if flush, else STALL if stall, else RUN.
REQ-027 stall_cycles SHALL increment each stall cycle; flush_events each flush cycle; both SHALL hold at all-ones (saturate).
REQ-028 Maximum stall per RAW dependency SHALL be 3 cycles (producer drains through WB).
REQ-029 Simultaneous hazard and flush SHALL count only a flush event, not a stall cycle.

Reset
REQ-030 While reset=1: scoreboard all v=0, state=RUN, counters=0; outputs SHALL be the RUN values of REQ-025 when id_valid=0 and mem_branch_taken=0.
REQ-031 Reset asserted mid-stall SHALL release the stall asynchronously (no match possible with empty scoreboard).

Verification
REQ-032 ADD X1 (rd=1) then SUB reading X1 as rn -> 3 cycles pc_write_en=0, idex_bubble=1; stall_cycles=3; state STALL then RUN.
REQ-033 Writer rd=31, reader rn=31 -> no stall; stall_cycles stays 0.
REQ-034 mem_branch_taken=1 while ID has hazard -> three flushes=1, pc_write_en=1, idex_bubble=0; flush_events=1, stall_cycles unchanged; next cycle EX/MEM entries invalid.
REQ-035 Independent instructions rd=2,3,4 then reader rn=5, rm=6 -> no stall, state RUN throughout.
REQ-036 Reset pulse during second stall cycle -> outputs return to RUN values before next clk edge, counters=0.
REQ-037 CNT_W=4, 20 stall cycles -> stall_cycles holds at 15.
